// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control-unit <-> datapath strobe and handshake bundle
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 3
);
  logic               run;
  logic [5:0]         op_code;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic               JumpAndLink;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               instr_done;
  logic [1:0]         fault;

  modport master (
    input  run, op_code, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, JumpAndLink, ALUSrcB, PCSource, ALUOp,
           instr_done, fault
  );

  modport slave (
    output run, op_code, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, JumpAndLink, ALUSrcB, PCSource, ALUOp,
           instr_done, fault
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory wait timeout and sticky fault
module multicycle_control_unit #(
  parameter int ALUOP_W     = 3,
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     reset_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_ALU, EXEC_I, WB_IMM,
    MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL_ST, FAULT
  } state_t;

  // Counter value seen in the last permitted wait cycle; only meaningful when the timeout is enabled.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  state_t            state;
  state_t            nextState;
  state_t            doneNext;
  logic [5:0]        opQ;
  logic [WAIT_W-1:0] waitCnt;
  logic [1:0]        faultQ;
  logic [1:0]        faultNext;
  logic [2:0]        aluOp3;
  logic              isWaitState;
  logic              waitExpired;

  assign isWaitState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // A ready in the final wait cycle still completes normally, so expiry requires mem_ready low.
  assign waitExpired = (MEM_TIMEOUT != 0) && !bus.mem_ready && (waitCnt == WAIT_LAST);
  assign doneNext    = bus.run ? FETCH : IDLE;
  assign bus.fault   = faultQ;

  // State, latched opcode, wait counter and fault code; everything returns to idle on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      opQ     <= 6'h00;
      waitCnt <= '0;
      faultQ  <= 2'b00;
    end else begin
      state  <= nextState;
      faultQ <= faultNext;
      if (state == DECODE) begin
        opQ <= bus.op_code;
      end
      if (nextState != state) begin
        waitCnt <= '0;
      end else if (isWaitState && !bus.mem_ready) begin
        waitCnt <= waitCnt + 1'b1;
      end
    end
  end

  // Next-state selection and per-state datapath strobes.
  always_comb begin
    nextState       = state;
    faultNext       = faultQ;
    aluOp3          = ALU_ADD;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.JumpAndLink = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.instr_done  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.run) nextState = FETCH;
      end

      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) begin
          nextState = DECODE;
        end else if (waitExpired) begin
          nextState = FAULT;
          faultNext = 2'b10;
        end
      end

      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.op_code)
          6'h00:               nextState = EXEC_R;
          6'h08, 6'h0C, 6'h0D: nextState = EXEC_I;
          6'h23, 6'h2B:        nextState = MEM_ADDR;
          6'h04:               nextState = BRANCH;
          6'h03:               nextState = JAL_ST;
          default: begin
            nextState = FAULT;
            faultNext = 2'b01;
          end
        endcase
      end

      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        aluOp3      = ALU_FUNCT;
        nextState   = WB_ALU;
      end

      WB_ALU: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        nextState      = doneNext;
      end

      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (opQ)
          6'h0C:   aluOp3 = ALU_AND;
          6'h0D:   aluOp3 = ALU_OR;
          default: aluOp3 = ALU_ADD;
        endcase
        nextState = WB_IMM;
      end

      WB_IMM: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        nextState      = doneNext;
      end

      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        nextState   = (opQ == 6'h23) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          nextState = WB_MEM;
        end else if (waitExpired) begin
          nextState = FAULT;
          faultNext = 2'b10;
        end
      end

      WB_MEM: begin
        bus.MemtoReg   = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        nextState      = doneNext;
      end

      MEM_WR: begin
        bus.IorD       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          nextState = doneNext;
        end else if (waitExpired) begin
          nextState = FAULT;
          faultNext = 2'b10;
        end
      end

      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        aluOp3          = ALU_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.instr_done  = 1'b1;
        nextState       = doneNext;
      end

      JAL_ST: begin
        bus.PCWrite     = 1'b1;
        bus.PCSource    = 2'b10;
        bus.RegWrite    = 1'b1;
        bus.JumpAndLink = 1'b1;
        bus.instr_done  = 1'b1;
        nextState       = doneNext;
      end

      default: begin
        nextState = FAULT;
      end
    endcase

    bus.ALUOp = ALUOP_W'(aluOp3);
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_unit_if #(.ALUOP_W(3)) bus ();

  multicycle_control_unit #(
    .ALUOP_W(3),
    .WAIT_W(8),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // [20] PCWrite [19] PCWriteCond [18] IorD [17] MemRead [16] MemWrite [15] IRWrite
  // [14] MemtoReg [13] RegDst [12] RegWrite [11] ALUSrcA [10] JumpAndLink
  // [9:8] ALUSrcB [7:6] PCSource [5:3] ALUOp [2] instr_done [1:0] fault
  localparam logic [20:0] PCW   = 21'h100000;
  localparam logic [20:0] PCWC  = 21'h080000;
  localparam logic [20:0] IORD  = 21'h040000;
  localparam logic [20:0] MRD   = 21'h020000;
  localparam logic [20:0] MWR   = 21'h010000;
  localparam logic [20:0] IRW   = 21'h008000;
  localparam logic [20:0] M2R   = 21'h004000;
  localparam logic [20:0] RDST  = 21'h002000;
  localparam logic [20:0] RWR   = 21'h001000;
  localparam logic [20:0] SRCA  = 21'h000800;
  localparam logic [20:0] JAL   = 21'h000400;
  localparam logic [20:0] B_4   = 21'h000100;
  localparam logic [20:0] B_IMM = 21'h000200;
  localparam logic [20:0] B_SH2 = 21'h000300;
  localparam logic [20:0] PC_AO = 21'h000040;
  localparam logic [20:0] PC_JT = 21'h000080;
  localparam logic [20:0] A_SUB = 21'h000008;
  localparam logic [20:0] A_FN  = 21'h000010;
  localparam logic [20:0] A_OR  = 21'h000020;
  localparam logic [20:0] DONE  = 21'h000004;
  localparam logic [20:0] F_ILL = 21'h000001;
  localparam logic [20:0] F_TMO = 21'h000002;

  localparam logic [20:0] E_FETCH = MRD | IRW | PCW | B_4;
  localparam logic [20:0] E_FWAIT = MRD | B_4;
  localparam logic [20:0] E_DEC   = B_SH2;
  localparam logic [20:0] E_ADDR  = SRCA | B_IMM;

  wire logic [20:0] obsVec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                              bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                              bus.JumpAndLink, bus.ALUSrcB, bus.PCSource, bus.ALUOp,
                              bus.instr_done, bus.fault};

  task automatic chk(input string tag, input logic [20:0] expected);
    total++;
    assert (obsVec === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obsVec, expected);
    end
  endtask

  // Drive this cycle's inputs, check the outputs, then advance one clock.
  task automatic step(input logic r, input logic mr, input logic [5:0] op,
                      input string tag, input logic [20:0] expected);
    bus.run       = r;
    bus.mem_ready = mr;
    bus.op_code   = op;
    #1;
    chk(tag, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n       = 1'b0;
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    bus.op_code   = 6'h00;
    #1;
    chk("reset_async", 21'h0);
    @(posedge clk);
    #1;
    chk("reset_held", 21'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.op_code   = 6'h00;
    #3;
    doReset();

    // R-type, zero wait
    step(1, 1, 6'h00, "r_idle",   21'h0);
    step(1, 1, 6'h00, "r_fetch",  E_FETCH);
    step(1, 1, 6'h00, "r_decode", E_DEC);
    step(1, 1, 6'h00, "r_exec",   SRCA | A_FN);
    step(1, 1, 6'h00, "r_wb",     RDST | RWR | DONE);

    // lw with three wait cycles in MEM_RD
    step(1, 1, 6'h23, "lw_fetch",  E_FETCH);
    step(1, 1, 6'h23, "lw_decode", E_DEC);
    step(1, 0, 6'h23, "lw_addr",   E_ADDR);
    step(1, 0, 6'h23, "lw_wait1",  IORD | MRD);
    step(1, 0, 6'h23, "lw_wait2",  IORD | MRD);
    step(1, 0, 6'h23, "lw_wait3",  IORD | MRD);
    step(1, 1, 6'h23, "lw_rd",     IORD | MRD);
    step(1, 1, 6'h23, "lw_wb",     M2R | RWR | DONE);

    // sw, beq, jal back to back
    step(1, 1, 6'h2B, "sw_fetch",   E_FETCH);
    step(1, 1, 6'h2B, "sw_decode",  E_DEC);
    step(1, 1, 6'h2B, "sw_addr",    E_ADDR);
    step(1, 1, 6'h2B, "sw_wr",      IORD | MWR | DONE);
    step(1, 1, 6'h04, "beq_fetch",  E_FETCH);
    step(1, 1, 6'h04, "beq_decode", E_DEC);
    step(1, 1, 6'h04, "beq_exec",   SRCA | A_SUB | PCWC | PC_AO | DONE);
    step(1, 1, 6'h03, "jal_fetch",  E_FETCH);
    step(1, 1, 6'h03, "jal_decode", E_DEC);
    step(1, 1, 6'h03, "jal_exec",   PCW | PC_JT | RWR | JAL | DONE);

    // addi with run dropped mid-instruction; opcode change after DECODE is ignored
    step(1, 1, 6'h08, "addi_fetch",  E_FETCH);
    step(1, 1, 6'h08, "addi_decode", E_DEC);
    step(0, 1, 6'h0D, "addi_exec",   E_ADDR);
    step(0, 1, 6'h0D, "addi_wb",     RWR | DONE);
    step(0, 1, 6'h00, "idle_hold1",  21'h0);
    step(0, 1, 6'h00, "idle_hold2",  21'h0);

    // sw interrupted by reset during the write wait
    step(1, 1, 6'h2B, "sw2_idle",   21'h0);
    step(1, 1, 6'h2B, "sw2_fetch",  E_FETCH);
    step(1, 1, 6'h2B, "sw2_decode", E_DEC);
    step(1, 0, 6'h2B, "sw2_addr",   E_ADDR);
    bus.mem_ready = 1'b0;
    #1;
    chk("sw2_wait", IORD | MWR);
    reset_n = 1'b0;
    #1;
    chk("sw2_reset_now", 21'h0);
    @(posedge clk);
    #1;
    chk("sw2_reset_hold", 21'h0);
    reset_n = 1'b1;

    // illegal opcode, sticky fault
    step(1, 1, 6'h3F, "ill_idle",   21'h0);
    step(1, 1, 6'h3F, "ill_fetch",  E_FETCH);
    step(1, 1, 6'h3F, "ill_decode", E_DEC);
    step(0, 0, 6'h00, "ill_f1",     F_ILL);
    step(1, 1, 6'h00, "ill_f2",     F_ILL);
    step(1, 0, 6'h23, "ill_f3",     F_ILL);
    step(0, 1, 6'h04, "ill_f4",     F_ILL);
    doReset();

    // fetch timeout after four wait cycles
    step(1, 0, 6'h00, "to_idle", 21'h0);
    step(1, 0, 6'h00, "to_w1",   E_FWAIT);
    step(1, 0, 6'h00, "to_w2",   E_FWAIT);
    step(1, 0, 6'h00, "to_w3",   E_FWAIT);
    step(1, 0, 6'h00, "to_w4",   E_FWAIT);
    step(1, 1, 6'h00, "to_fault", F_TMO);
    step(0, 1, 6'h00, "to_hold",  F_TMO);
    doReset();

    // ready on the last allowed wait cycle wins; then ori
    step(1, 0, 6'h0D, "tw_idle",   21'h0);
    step(1, 0, 6'h0D, "tw_w1",     E_FWAIT);
    step(1, 0, 6'h0D, "tw_w2",     E_FWAIT);
    step(1, 0, 6'h0D, "tw_w3",     E_FWAIT);
    step(1, 1, 6'h0D, "tw_fetch",  E_FETCH);
    step(1, 1, 6'h0D, "tw_decode", E_DEC);
    step(1, 1, 6'h0D, "tw_exec",   E_ADDR | A_OR);
    step(0, 1, 6'h0D, "tw_wb",     RWR | DONE);
    step(0, 1, 6'h0D, "tw_idle2",  21'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
